// File: rtl/mysoc_ram_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port RAM with 1-cycle read latency.
// Out-of-range accesses are accepted but never reach the RAM; they raise a sticky oor_err.
module mysoc_ram_arbiter #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 10240
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W-1:0]   m0_writedata,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_readdata,
  output logic                m0_readdatavalid,
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W-1:0]   m1_writedata,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic                m1_readdatavalid,
  output logic [ADDR_W-1:0]   ram_address,
  output logic [DATA_W/8-1:0] ram_byteenable,
  output logic                ram_chipselect,
  output logic                ram_write,
  output logic [DATA_W-1:0]   ram_writedata,
  output logic                ram_clken,
  input  logic [DATA_W-1:0]   ram_readdata,
  output logic                oor_err,
  input  logic                oor_err_clr
);

  localparam logic [ADDR_W:0] DEPTH_LIM = DEPTH[ADDR_W:0];

  logic req0, req1, grant0, grant1, any_grant;
  logic last_grant;
  logic sel_read, sel_write, in_range, acc_read, acc_oor;
  logic rd_valid, rd_owner, rd_oor;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

  // On a tie, the requester that did not win last time gets the slot.
  assign grant0    = req0 & (~req1 | last_grant);
  assign grant1    = req1 & (~req0 | ~last_grant);
  assign any_grant = grant0 | grant1;

  assign m0_waitrequest = req0 & ~grant0;
  assign m1_waitrequest = req1 & ~grant1;

  assign ram_address    = grant1 ? m1_address    : m0_address;
  assign ram_byteenable = grant1 ? m1_byteenable : m0_byteenable;
  assign ram_writedata  = grant1 ? m1_writedata  : m0_writedata;
  assign sel_read       = grant1 ? m1_read       : m0_read;
  assign sel_write      = grant1 ? m1_write      : m0_write;
  assign in_range       = {1'b0, ram_address} < DEPTH_LIM;

  // Read+write together counts as a write, so it never occupies the return path.
  assign acc_read = any_grant & sel_read & ~sel_write;
  assign acc_oor  = any_grant & ~in_range;

  assign ram_chipselect = reset_n & any_grant & in_range;
  assign ram_write      = ram_chipselect & sel_write;
  assign ram_clken      = 1'b1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant <= 1'b1;
      rd_valid   <= 1'b0;
      rd_owner   <= 1'b0;
      rd_oor     <= 1'b0;
      oor_err    <= 1'b0;
    end else begin
      if (any_grant) begin
        last_grant <= grant1;
      end
      rd_valid <= acc_read;
      if (acc_read) begin
        rd_owner <= grant1;
        rd_oor   <= ~in_range;
      end
      if (acc_oor) begin
        oor_err <= 1'b1;
      end else if (oor_err_clr) begin
        oor_err <= 1'b0;
      end
    end
  end

  assign m0_readdatavalid = rd_valid & ~rd_owner;
  assign m1_readdatavalid = rd_valid & rd_owner;
  assign m0_readdata      = (rd_valid & ~rd_oor) ? ram_readdata : '0;
  assign m1_readdata      = (rd_valid & ~rd_oor) ? ram_readdata : '0;

endmodule

// File: tb/tb_mysoc_ram_arbiter.sv
// Scoreboard bench for mysoc_ram_arbiter: a behavioral RAM answers the DUT, a reference
// memory plus a round-robin model predict grants, read returns and oor_err.
module tb_mysoc_ram_arbiter;
  localparam int ADDR_W = 14;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 10240;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic [13:0] m0_address, m1_address;
  logic [3:0]  m0_byteenable, m1_byteenable;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [31:0] m0_writedata, m1_writedata;
  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] m0_readdata, m1_readdata;
  logic        m0_readdatavalid, m1_readdatavalid;
  logic [13:0] ram_address;
  logic [3:0]  ram_byteenable;
  logic        ram_chipselect, ram_write, ram_clken;
  logic [31:0] ram_writedata, ram_readdata;
  logic        oor_err, oor_err_clr;

  mysoc_ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
    .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .ram_address(ram_address), .ram_byteenable(ram_byteenable),
    .ram_chipselect(ram_chipselect), .ram_write(ram_write), .ram_writedata(ram_writedata),
    .ram_clken(ram_clken), .ram_readdata(ram_readdata),
    .oor_err(oor_err), .oor_err_clr(oor_err_clr)
  );

  // Behavioral single-port RAM, registered read.
  logic [31:0] mem [0:16383];
  logic [31:0] ref_mem [0:16383];
  logic [31:0] ram_rd_q = '0;
  always @(posedge clk) begin
    if (ram_chipselect) begin
      if (ram_write) begin
        for (int b = 0; b < 4; b++)
          if (ram_byteenable[b]) mem[ram_address][b*8 +: 8] <= ram_writedata[b*8 +: 8];
      end else begin
        ram_rd_q <= mem[ram_address];
      end
    end
  end
  assign ram_readdata = ram_rd_q;

  int total = 0;
  int bad = 0;
  logic [31:0] q0[$];
  logic [31:0] q1[$];
  logic m_last, m_oor, acc0, acc1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_acc(input int n, input logic rd, input logic wr, input logic [13:0] a,
                           input logic [3:0] be, input logic [31:0] d);
    logic [31:0] e;
    logic inr;
    inr = (a < DEPTH);
    if (wr) begin
      if (inr)
        for (int b = 0; b < 4; b++) if (be[b]) ref_mem[a][b*8 +: 8] = d[b*8 +: 8];
      $display("txn m%0d wr addr=%0d be=%b data=%h%s", n, a, be, d, inr ? "" : " (oor)");
    end else if (rd) begin
      e = inr ? ref_mem[a] : 32'h0;
      if (n == 0) q0.push_back(e); else q1.push_back(e);
      $display("txn m%0d rd addr=%0d exp=%h%s", n, a, e, inr ? "" : " (oor)");
    end
  endtask

  // One clock cycle: inputs already driven at posedge+1; check at the falling edge.
  task automatic step();
    logic r0, r1, g0, g1, in0, in1;
    logic [31:0] e;
    #4;
    check_eq("rdv0", {31'b0, m0_readdatavalid}, {31'b0, q0.size() != 0});
    if (q0.size() != 0) begin e = q0.pop_front(); check_eq("rdata0", m0_readdata, e); end
    check_eq("rdv1", {31'b0, m1_readdatavalid}, {31'b0, q1.size() != 0});
    if (q1.size() != 0) begin e = q1.pop_front(); check_eq("rdata1", m1_readdata, e); end
    check_eq("oor_err", {31'b0, oor_err}, {31'b0, m_oor});
    check_eq("clken", {31'b0, ram_clken}, 32'd1);
    r0 = m0_read | m0_write;
    r1 = m1_read | m1_write;
    g0 = r0 & (!r1 | m_last);
    g1 = r1 & (!r0 | !m_last);
    in0 = (m0_address < DEPTH);
    in1 = (m1_address < DEPTH);
    check_eq("wait0", {31'b0, m0_waitrequest}, {31'b0, r0 & !g0});
    check_eq("wait1", {31'b0, m1_waitrequest}, {31'b0, r1 & !g1});
    check_eq("ram_cs", {31'b0, ram_chipselect}, {31'b0, (g0 & in0) | (g1 & in1)});
    check_eq("ram_wr", {31'b0, ram_write},
             {31'b0, (g0 & in0 & m0_write) | (g1 & in1 & m1_write)});
    if (g0 & in0) check_eq("ram_addr0", {18'b0, ram_address}, {18'b0, m0_address});
    if (g1 & in1) check_eq("ram_addr1", {18'b0, ram_address}, {18'b0, m1_address});
    if (g0 & in0 & m0_write) begin
      check_eq("ram_wd0", ram_writedata, m0_writedata);
      check_eq("ram_be0", {28'b0, ram_byteenable}, {28'b0, m0_byteenable});
    end
    if (g1 & in1 & m1_write) begin
      check_eq("ram_wd1", ram_writedata, m1_writedata);
      check_eq("ram_be1", {28'b0, ram_byteenable}, {28'b0, m1_byteenable});
    end
    if (g0) model_acc(0, m0_read, m0_write, m0_address, m0_byteenable, m0_writedata);
    if (g1) model_acc(1, m1_read, m1_write, m1_address, m1_byteenable, m1_writedata);
    if ((g0 & !in0) | (g1 & !in1)) m_oor = 1'b1;
    else if (oor_err_clr) m_oor = 1'b0;
    if (g0) m_last = 1'b0;
    if (g1) m_last = 1'b1;
    acc0 = g0;
    acc1 = g1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0;
  endtask

  initial begin
    reset_n = 1'b0;
    oor_err_clr = 1'b0;
    idle_all();
    m0_address = '0; m1_address = '0; m0_byteenable = 4'hF; m1_byteenable = 4'hF;
    m0_writedata = '0; m1_writedata = '0;
    for (int i = 0; i < 16384; i++) begin mem[i] = '0; ref_mem[i] = '0; end
    mem[5] = 32'h12345678; ref_mem[5] = 32'h12345678;
    mem[3] = 32'hCAFE0003; ref_mem[3] = 32'hCAFE0003;
    mem[4] = 32'hBEEF0004; ref_mem[4] = 32'hBEEF0004;
    m_last = 1'b1; m_oor = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_rdv0", {31'b0, m0_readdatavalid}, 32'd0);
    check_eq("rst_rdv1", {31'b0, m1_readdatavalid}, 32'd0);
    check_eq("rst_rdata0", m0_readdata, 32'd0);
    check_eq("rst_rdata1", m1_readdata, 32'd0);
    check_eq("rst_cs", {31'b0, ram_chipselect}, 32'd0);
    check_eq("rst_wr", {31'b0, ram_write}, 32'd0);
    check_eq("rst_clken", {31'b0, ram_clken}, 32'd1);
    check_eq("rst_oor", {31'b0, oor_err}, 32'd0);
    reset_n = 1'b1;

    // m0 read of preloaded address 5
    m0_read = 1; m0_address = 14'd5;
    step();
    idle_all();
    check_eq("first_read", m0_readdata, 32'h12345678);
    step();

    // continuous contention: grants must alternate
    m0_read = 1; m0_address = 14'd1;
    m1_write = 1; m1_address = 14'd2; m1_writedata = 32'hA5A5A5A5; m1_byteenable = 4'hF;
    repeat (8) step();
    idle_all();
    step();

    // byte-lane write then immediate read of the same word
    m1_write = 1; m1_address = 14'd7; m1_writedata = 32'hFFFFFFFF; m1_byteenable = 4'b0010;
    step();
    m1_write = 0; m0_read = 1; m0_address = 14'd7;
    step();
    idle_all();
    check_eq("be_merge", m0_readdata, 32'h0000FF00);
    step();

    // out-of-range read, sticky flag, clear
    m0_read = 1; m0_address = 14'd10240;
    step();
    idle_all();
    step();
    step();
    oor_err_clr = 1;
    step();
    oor_err_clr = 0;
    step();
    m1_write = 1; m1_address = 14'd12000; m1_writedata = 32'h11111111;
    step();
    m1_write = 0; m1_read = 1;
    step();
    idle_all();
    step();

    // pipelined reads from different owners
    m0_read = 1; m0_address = 14'd3;
    step();
    m0_read = 0; m1_read = 1; m1_address = 14'd4;
    step();
    idle_all();
    check_eq("pipe_m1", m1_readdata, 32'hBEEF0004);
    step();

    // reset in the middle of a read
    m0_read = 1; m0_address = 14'd10300;
    step();
    idle_all();
    m0_read = 1; m0_address = 14'd5;
    #4;
    check_eq("pre_rst_wait0", {31'b0, m0_waitrequest}, 32'd0);
    reset_n = 1'b0;
    m0_read = 0;
    #1;
    check_eq("mid_rst_rdv0", {31'b0, m0_readdatavalid}, 32'd0);
    check_eq("mid_rst_rdata0", m0_readdata, 32'd0);
    check_eq("mid_rst_cs", {31'b0, ram_chipselect}, 32'd0);
    check_eq("mid_rst_oor", {31'b0, oor_err}, 32'd0);
    @(posedge clk); #1;
    check_eq("rst_hold_rdv0", {31'b0, m0_readdatavalid}, 32'd0);
    @(posedge clk); #1;
    q0.delete(); q1.delete();
    m_last = 1'b1; m_oor = 1'b0;
    reset_n = 1'b1;
    m0_read = 1; m0_address = 14'd3; m1_read = 1; m1_address = 14'd4;
    step();
    check_eq("tie_after_rst", {31'b0, acc0}, 32'd1);
    m0_read = 0;
    step();
    idle_all();
    step();

    // random traffic; a waiting requester holds its request
    for (int i = 0; i < 300; i++) begin
      if (acc0 || !(m0_read | m0_write)) begin
        int op;
        op = $urandom_range(0, 4);
        m0_read = (op == 1 || op == 2 || op == 4);
        m0_write = (op == 3 || op == 4);
        m0_address = ($urandom_range(0, 7) == 0) ? 14'($urandom_range(10230, 10250))
                                                 : 14'($urandom_range(0, 15));
        m0_byteenable = 4'($urandom_range(0, 15));
        m0_writedata = $urandom;
      end
      if (acc1 || !(m1_read | m1_write)) begin
        int op;
        op = $urandom_range(0, 4);
        m1_read = (op == 1 || op == 2 || op == 4);
        m1_write = (op == 3 || op == 4);
        m1_address = ($urandom_range(0, 7) == 0) ? 14'($urandom_range(10230, 10250))
                                                 : 14'($urandom_range(0, 15));
        m1_byteenable = 4'($urandom_range(0, 15));
        m1_writedata = $urandom;
      end
      oor_err_clr = ($urandom_range(0, 7) == 0);
      step();
    end
    idle_all();
    oor_err_clr = 0;
    step();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
